selfcomp_leak_monitor: RTL
==========================

SELFCOMP_LEAK_MONITOR -- requirements
Module: selfcomp_leak_monitor

Interface
REQ-001 SHALL have parameter NUM_COPIES, default 2, number of self-composed DUT copies observed (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 128, width of each copy's result.
REQ-003 SHALL have parameter CNT_W, default 8, width of latency and skew counters.
REQ-004 SHALL have parameter MAX_SKEW, default 16, cycles to wait for lagging copies after the first copy's valid.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserting it low clears all state immediately.
REQ-007 in_fire  input  1  transaction start, i.e. the shared io_in_valid AND io_in_ready.
REQ-008 copy_valid  input  NUM_COPIES  per-copy io_out_valid.
REQ-009 copy_result  input  NUM_COPIES*DATA_W  per-copy io_out_result; copy k occupies bits [k*DATA_W +: DATA_W].
REQ-010 clear  input  1  clears sticky leak flags.
REQ-011 any_valid  output  1  OR of copy_valid, combinational.
REQ-012 all_valid  output  1  AND of copy_valid, combinational.
REQ-013 timing_leak  output  1  sticky: copies' first valids arrived on different cycles.
REQ-014 value_leak  output  1  sticky: copy results differ.
REQ-015 leak_done  output  1  one-cycle pulse when a transaction's check completes.
REQ-016 timeout  output  1  sticky: a copy failed to respond within MAX_SKEW.
REQ-017 latency  output  CNT_W  cycles from in_fire to the first copy's valid, held until the next check.
REQ-018 skew  output  CNT_W  cycles from the first copy's valid to the last, held until the next check.

Function
REQ-019 FSM states SHALL be IDLE, ARMED, WAIT_REST and DONE.
REQ-020 IDLE->ARMED on in_fire; the latency counter loads 0 and the seen mask clears.
REQ-021 In ARMED, the latency counter SHALL increment each cycle, saturating at 2^CNT_W-1.
REQ-022 In ARMED, the first cycle with any copy_valid high SHALL latch that valid set into the seen mask and copy latency to the output.
REQ-023 From that cycle: if all copies are valid, go to DONE with skew=0; otherwise go to WAIT_REST, set timing_leak and set skew=1.
REQ-024 In WAIT_REST, each cycle OR copy_valid into the seen mask and increment skew, saturating.
REQ-025 WAIT_REST->DONE when the seen mask is all ones.
REQ-026 WAIT_REST->DONE with timeout set when skew reaches MAX_SKEW.
REQ-027 In DONE, leak_done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-028 Total check latency SHALL be the last-copy cycle plus 1.
REQ-029 in_fire outside IDLE SHALL be ignored; no second transaction is tracked.
REQ-030 Each copy's result SHALL be captured on the first cycle its valid is seen.
REQ-031 On entry to DONE, any captured result differing from copy 0's SHALL set value_leak; timed-out copies are excluded from the compare.
REQ-032 clear SHALL zero timing_leak, value_leak and timeout; a set event in the same cycle as clear SHALL win.
REQ-033 A copy's valid deasserting after it is seen SHALL be ignored; the seen mask is monotonic within a transaction.

Reset
REQ-034 While reset is low: state=IDLE; seen mask, captured results, latency and skew =0; timing_leak, value_leak, timeout and leak_done =0.
REQ-035 Reset mid-transaction SHALL abandon it without a leak_done pulse.

Configuration
REQ-036 With SELFCOMP_VALUE_CHECK_EN defined, result capture and compare SHALL be implemented as specified.
REQ-037 Without SELFCOMP_VALUE_CHECK_EN, value_leak SHALL be tied to 0, no result storage is instantiated, and copy_result is unused.

Structure
REQ-038 A shared package selfcomp_pkg SHALL hold the FSM state enum and the default constants (DATA_W 128, CNT_W 8, MAX_SKEW 16).
REQ-039 Saturating counting SHALL use one sub-module, selfcomp_sat_cnt, instantiated for latency and for skew.

Verification
REQ-040 NUM_COPIES=2; in_fire at t0; both copies valid at t0+5 -> latency=5, skew=0, leak_done at t0+6, no flags set.
REQ-041 NUM_COPIES=2; copy0 valid at t0+3, copy1 valid at t0+7 -> timing_leak=1, latency=3, skew=4, leak_done one cycle after copy1's valid.
REQ-042 NUM_COPIES=4; copy3 never valid, MAX_SKEW=16 -> timeout=1 and timing_leak=1 sixteen cycles after the first valid; value_leak=0 with copies 0-2 all 0xA5.
REQ-043 With SELFCOMP_VALUE_CHECK_EN, simultaneous valids, results 0x1 vs 0x2 -> value_leak=1, timing_leak=0; without the macro -> value_leak=0.
REQ-044 Reset low during WAIT_REST -> next cycle state=IDLE, all flags 0, no leak_done pulse.
REQ-045 clear in the same cycle as a timing_leak set event -> timing_leak=1; clear alone next cycle -> 0.

Source files
------------

// File: rtl/selfcomp_pkg.sv
// Shared definitions for the self-composition leak monitor: FSM state
// encoding and the default sizing constants used by the top level.
package selfcomp_pkg;

  localparam int DEF_DATA_W   = 128;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_MAX_SKEW = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    WAIT_REST = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/selfcomp_sat_cnt.sv
// Saturating up-counter with synchronous load. Used for the latency and
// skew measurements; it holds at all-ones instead of wrapping.
module selfcomp_sat_cnt
  import selfcomp_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Load has priority over increment; increment stops at the maximum value.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// Observes NUM_COPIES self-composed copies of a design that were started by
// the same transaction and flags timing leaks (copies answering on
// different cycles), value leaks (copies answering with different results)
// and copies that never answer within MAX_SKEW cycles of the first one.
// Optional feature macro: SELFCOMP_VALUE_CHECK_EN enables result capture
// and the value compare; without it value_leak is constant 0.
module selfcomp_leak_monitor
  import selfcomp_pkg::*;
#(
  parameter int NUM_COPIES = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_SKEW   = DEF_MAX_SKEW
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_fire,
  input  logic [NUM_COPIES-1:0]        copy_valid,
  input  logic [NUM_COPIES*DATA_W-1:0] copy_result,
  input  logic                         clear,
  output logic                         any_valid,
  output logic                         all_valid,
  output logic                         timing_leak,
  output logic                         value_leak,
  output logic                         leak_done,
  output logic                         timeout,
  output logic [CNT_W-1:0]             latency,
  output logic [CNT_W-1:0]             skew
);

  // Skew value at which the next WAIT_REST increment reaches MAX_SKEW.
  localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(MAX_SKEW - 1);

  state_t                state;
  state_t                state_nxt;
  logic [NUM_COPIES-1:0] seen;
  logic [NUM_COPIES-1:0] capture;
  logic [CNT_W-1:0]      lat_cnt;
  logic                  lat_load;
  logic                  lat_inc;
  logic                  skew_load;
  logic                  skew_inc;
  logic [CNT_W-1:0]      skew_load_val;
  logic                  tl_set;
  logic                  to_set;

  assign any_valid = |copy_valid;
  assign all_valid = &copy_valid;
  assign leak_done = (state == DONE);

  // Next-state and per-cycle control decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    lat_load      = 1'b0;
    lat_inc       = 1'b0;
    skew_load     = 1'b0;
    skew_load_val = '0;
    skew_inc      = 1'b0;
    tl_set        = 1'b0;
    to_set        = 1'b0;
    capture       = '0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_nxt = ARMED;
          lat_load  = 1'b1;
        end
      end
      ARMED: begin
        lat_inc = 1'b1;
        if (any_valid) begin
          capture   = copy_valid;
          skew_load = 1'b1;
          if (all_valid) begin
            state_nxt = DONE;
          end else begin
            state_nxt     = WAIT_REST;
            skew_load_val = CNT_W'(1);
            tl_set        = 1'b1;
          end
        end
      end
      WAIT_REST: begin
        capture = copy_valid & ~seen;
        if (&(seen | copy_valid)) begin
          state_nxt = DONE;
        end else begin
          skew_inc = 1'b1;
          if (skew >= SKEW_LAST) begin
            state_nxt = DONE;
            to_set    = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Seen mask: cleared at transaction start, only ever gains bits after that.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen <= '0;
    end else if (state == IDLE && in_fire) begin
      seen <= '0;
    end else begin
      seen <= seen | capture;
    end
  end

  // Cycles since in_fire; counts through the detecting cycle as well.
  selfcomp_sat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clock),
    .rst_n    (reset),
    .load     (lat_load),
    .load_val ('0),
    .inc      (lat_inc),
    .count    (lat_cnt)
  );

  // Skew counter drives the output directly; it only moves during a check.
  selfcomp_sat_cnt #(.W(CNT_W)) u_skew_cnt (
    .clk      (clock),
    .rst_n    (reset),
    .load     (skew_load),
    .load_val (skew_load_val),
    .inc      (skew_inc),
    .count    (skew)
  );

  // Latency output: the saturated count including the first-valid cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      latency <= '0;
    end else if (state == ARMED && any_valid) begin
      latency <= (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
    end
  end

  // Sticky timing/timeout flags; a set in the same cycle as clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timing_leak <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timing_leak <= (timing_leak & ~clear) | tl_set;
      timeout     <= (timeout & ~clear) | to_set;
    end
  end

`ifdef SELFCOMP_VALUE_CHECK_EN
  logic [DATA_W-1:0]     cap_q [NUM_COPIES];
  logic [DATA_W-1:0]     eff   [NUM_COPIES];
  logic [NUM_COPIES-1:0] eff_seen;
  logic                  mismatch;
  logic                  vl_set;

  // Capture each copy's result on the first cycle its valid is seen.
  // NOTE: the result store is reset like any other state so a compare can
  // never observe X or a previous power-up's contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_COPIES; k++) cap_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_COPIES; k++) begin
        if (capture[k]) cap_q[k] <= copy_result[k*DATA_W +: DATA_W];
      end
    end
  end

  // Compare against copy 0 including results captured this very cycle, so
  // the flag is visible together with leak_done. Unseen copies are skipped.
  always_comb begin
    eff_seen = seen | capture;
    mismatch = 1'b0;
    for (int k = 0; k < NUM_COPIES; k++) begin
      eff[k] = capture[k] ? copy_result[k*DATA_W +: DATA_W] : cap_q[k];
    end
    for (int k = 1; k < NUM_COPIES; k++) begin
      if (eff_seen[0] && eff_seen[k] && (eff[k] != eff[0])) mismatch = 1'b1;
    end
  end

  assign vl_set = mismatch && (state_nxt == DONE);

  // Sticky value flag; a set in the same cycle as clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_leak <= 1'b0;
    end else begin
      value_leak <= (value_leak & ~clear) | vl_set;
    end
  end
`else
  logic unused_result;
  assign unused_result = ^copy_result;
  assign value_leak    = 1'b0;
`endif

endmodule
